// File: rtl/stopwatch_bcd.sv
// Serial double-dabble binary-to-BCD converter for a stopwatch display, valid/ready on both sides.
// Define STOPWATCH_BCD_BLANK_EN to compile in leading-zero blank flags; otherwise blank is all zeros.
module stopwatch_bcd #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIGITS     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sreg;
  logic [SW-1:0]         r_scratch;
  logic [CW-1:0]         r_cnt;
  logic                  r_out_valid;
  logic [SW-1:0]         r_bcd;
  logic [DIGITS-1:0]     r_blank;

  logic [SW-1:0]         w_adj;
  logic [SW-1:0]         w_next;
  logic [DIGITS-1:0]     w_blank;

  // Add-3 correction on every digit that would overflow past 9 after doubling
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_next = (w_adj << 1) | SW'(r_sreg[DATA_WIDTH-1]);

  // Blank flags are derived from the value about to be loaded, so they stay aligned with bcd
  always_comb begin
    w_blank = '0;
`ifdef STOPWATCH_BCD_BLANK_EN
    begin
      logic w_zero;
      w_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        w_zero     = w_zero & (w_next[4*i +: 4] == 4'd0);
        w_blank[i] = w_zero;
      end
    end
`else
    w_blank = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sreg      <= '0;
      r_scratch   <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_bcd       <= '0;
      r_blank     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sreg    <= bin;
            r_scratch <= '0;
            r_cnt     <= CW'(DATA_WIDTH);
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= w_next;
          r_sreg    <= r_sreg << 1;
          r_cnt     <= r_cnt - CW'(1);
          // Last shift: publish the finished result; outputs never see partial values
          if (r_cnt == CW'(1)) begin
            r_bcd       <= w_next;
            r_blank     <= w_blank;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;
  assign blank     = r_blank;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: constant vector table, hand sequences for handshake/reset corners,
// and randomized conversions checked against a decimal-arithmetic reference model.
module tb_stopwatch_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bin;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int n_cmp = 0;
  int n_err = 0;

  stopwatch_bcd #(.DATA_WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .blank(blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b;
    logic [19:0] exp_bcd;
    logic [4:0]  exp_blank_en;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] build_blank(input logic [4:0] b);
`ifdef STOPWATCH_BCD_BLANK_EN
    return b;
`else
    return 5'b0;
`endif
  endfunction

  // Reference: decimal digits by repeated division
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: every digit position at or above the significant digit count is blank
  function automatic logic [4:0] ref_blank(input int unsigned v);
    logic [4:0] r;
    int ndig;
    ndig = 1;
    while (v >= 10) begin
      v = v / 10;
      ndig++;
    end
    r = '0;
    for (int i = 1; i < 5; i++) if (i >= ndig) r[i] = 1'b1;
    return build_blank(r);
  endfunction

  // One full conversion: latency, result, hold stability with ignored in_valid, handshake, retention
  task automatic conv(input string nm, input logic [15:0] b, input logic [19:0] eb,
                      input logic [4:0] ebl, input int hold, input bit scramble);
    int lat;
    lat = 0;
    while (!in_ready && lat < 40) begin tick(); lat++; end
    chk({nm, " in_ready before accept"}, 32'(in_ready), 32'd1);
    bin = b; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        bin = 16'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk({nm, " latency"}, 32'(lat), 32'd16);
    chk({nm, " bcd"}, 32'(bcd), 32'(eb));
    chk({nm, " blank"}, 32'(blank), 32'(ebl));
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid; bin = 16'd7;
      tick();
      chk({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " hold bcd"}, 32'(bcd), 32'(eb));
      chk({nm, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " out_valid cleared"}, 32'(out_valid), 32'd0);
    chk({nm, " in_ready after ack"}, 32'(in_ready), 32'd1);
    chk({nm, " bcd retained"}, 32'(bcd), 32'(eb));
  endtask

  initial begin
    vec_t tbl[8];
    logic [15:0] q[$];
    logic [15:0] v;
    int last_acc, cyc, got;
    bit acc;

    tbl[0] = '{16'd0,     20'h00000, 5'b11110};
    tbl[1] = '{16'd99,    20'h00099, 5'b11100};
    tbl[2] = '{16'd65535, 20'h65535, 5'b00000};
    tbl[3] = '{16'd10000, 20'h10000, 5'b00000};
    tbl[4] = '{16'd1000,  20'h01000, 5'b10000};
    tbl[5] = '{16'd9,     20'h00009, 5'b11110};
    tbl[6] = '{16'd10,    20'h00010, 5'b11100};
    tbl[7] = '{16'd40960, 20'h40960, 5'b00000};

    // Reset with in_valid high on the same edges: reset must win
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; bin = 16'd123;
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset bcd", 32'(bcd), 32'd0);
    chk("reset blank", 32'(blank), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++)
      conv($sformatf("vec%0d", i), tbl[i].b, tbl[i].exp_bcd, build_blank(tbl[i].exp_blank_en), 0, 1'b0);

    // Consumer stalls 5 cycles while bin=7 pulses are presented and must be ignored
    conv("stall", 16'd42, 20'h00042, build_blank(5'b11100), 5, 1'b0);

    // Reset after the 8th shift edge aborts the conversion
    bin = 16'd4321; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort bcd", 32'(bcd), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    conv("after abort", 16'd1234, 20'h01234, build_blank(5'b10000), 0, 1'b0);

    // Inputs churn during SHIFT; result must reflect the accepted value only
    conv("scramble500", 16'd500, 20'h00500, build_blank(5'b11000), 0, 1'b1);

    // Randomized conversions against the reference model
    for (int k = 0; k < 30; k++) begin
      v = 16'($urandom);
      if (k % 5 == 0) v = 16'($urandom_range(0, 120));
      conv($sformatf("rand%0d(%0d)", k, v), v, ref_bcd(v), ref_blank(v),
           $urandom_range(0, 3), 1'($urandom));
    end

    // Back-to-back stream, out_ready tied high, bins 0..99 from a counter
    bin = 16'd0; in_valid = 1'b1; out_ready = 1'b1;
    last_acc = -1; cyc = 0; got = 0;
    while (got < 100 && cyc < 3000) begin
      acc = in_ready && in_valid;
      tick();
      cyc++;
      if (acc) begin
        q.push_back(bin);
        if (last_acc >= 0) chk($sformatf("stream interval %0d", bin), 32'(cyc - last_acc), 32'd18);
        last_acc = cyc;
        if (bin == 16'd99) in_valid = 1'b0;
        else bin = bin + 16'd1;
      end
      if (out_valid) begin
        if (q.size() == 0) chk("stream unexpected result", 32'(out_valid), 32'd0);
        else begin
          v = q.pop_front();
          chk($sformatf("stream bcd %0d", v), 32'(bcd), 32'(ref_bcd(v)));
        end
        got++;
      end
    end
    chk("stream result count", 32'(got), 32'd100);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, binary count width from the stopwatch counter.
REQ-002 SHALL have parameter DIGITS, default 5, number of BCD output digits; legal only if 10^DIGITS > 2^DATA_WIDTH-1; not checked in RTL.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  bin is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  converter can accept bin; high only in IDLE.
REQ-007 SHALL have port bin  input  DATA_WIDTH  binary value to convert, typically the stopwatch count.
REQ-008 SHALL have port out_valid  output  1  bcd/blank hold a completed, unacknowledged result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
REQ-011 SHALL have port blank  output  DIGITS  per-digit leading-zero blank flags (see Configuration).

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 SHALL accept input on a clock edge where state==IDLE and in_valid==1: latch bin into a shift register, clear the BCD scratch register, load bit counter DATA_WIDTH, go to SHIFT.
REQ-014 SHALL, in each SHIFT cycle, add 3 to every scratch digit >=5, then shift {scratch, shift register} left by one; the bin MSB enters scratch bit 0.
REQ-015 SHALL perform exactly DATA_WIDTH SHIFT cycles, then on the final SHIFT edge load bcd (and blank) from the result and go to DONE with out_valid=1.
REQ-016 SHALL assert out_valid exactly DATA_WIDTH clock edges after the accepting edge; throughput is one conversion per DATA_WIDTH+2 cycles at best.
REQ-017 SHALL hold out_valid, bcd and blank stable in DONE until out_ready==1; on that edge it SHALL clear out_valid and return to IDLE.
REQ-018 SHALL retain bcd and blank after the handshake until the next result is loaded, so a display can read them continuously.
REQ-019 SHALL drive in_ready combinationally as (state==IDLE); in_valid outside IDLE SHALL be ignored, with no queuing.
REQ-020 SHALL NOT depend on in_valid, bin or out_ready in SHIFT; input changes mid-conversion SHALL not affect the result.
REQ-021 SHALL not update bcd or blank during SHIFT; intermediate scratch values are never visible on outputs.
REQ-022 SHALL convert bin==0 and bin==2^DATA_WIDTH-1 correctly.

Reset
REQ-023 SHALL, when reset==1 at a clock edge, in any state including mid-SHIFT, go to IDLE, abort any conversion, and set out_valid=0, bcd=0, blank=0, scratch and bit counter = 0.
REQ-024 SHALL have in_ready==1 in the first cycle after reset deasserts.
REQ-025 SHALL give reset priority over in_valid and out_ready on the same edge.

Configuration
REQ-026 SHALL use macro STOPWATCH_BCD_BLANK_EN to compile in leading-zero blanking.
REQ-027 SHALL, with STOPWATCH_BCD_BLANK_EN defined, set blank[i] (i>=1) at result load when digit i and all higher digits are zero; blank[0] SHALL always be 0; blank is registered together with bcd.
REQ-028 SHALL, without STOPWATCH_BCD_BLANK_EN, tie blank to all zeros; bcd behaviour and timing SHALL be identical in both builds.

Verification (DATA_WIDTH=16, DIGITS=5)
REQ-029 SHALL cover: bin=0 accepted -> out_valid 16 edges later, bcd=20'h00000, blank=5'b11110 (BLANK_EN) or 5'b00000.
REQ-030 SHALL cover: bin=99 -> bcd=20'h00099, blank=5'b11100 (BLANK_EN); bin=65535 -> bcd=20'h65535, blank=5'b00000.
REQ-031 SHALL cover: out_ready held low 5 cycles after out_valid -> bcd/out_valid stable, in_ready=0, in_valid pulses with bin=7 ignored; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
REQ-032 SHALL cover: reset asserted after the 8th SHIFT edge of bin=4321 -> out_valid=0, bcd=0, in_ready=1; then bin=1234 -> bcd=20'h01234.
REQ-033 SHALL cover: back-to-back in_valid with out_ready tied high, bins 0..99 from the stopwatch counter -> each bcd matches decimal of bin; a new accept occurs every 18 cycles.
REQ-034 SHALL cover: bin changed every cycle during SHIFT after accepting bin=500 -> bcd=20'h00500.
